// File: rtl/test_status_monitor.sv
// Snoops CPU data-memory stores to a tohost word and keeps a sticky test verdict plus a RUN watchdog.
// Optional signature capture is built when TEST_MON_SIGNATURE_EN is defined.
module test_status_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count,
  output logic        proto_err,
  output logic [31:0] sig_value,
  output logic [15:0] sig_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  state_t state;

  logic tohost_hit;
  logic full_hit;
  logic part_hit;
  logic pass_hit;
  logic fail_hit;
  logic sig_hit;
  logic unused_addr_lsbs;

  // Byte offset within the word is irrelevant; only the word address is decoded.
  assign unused_addr_lsbs = &{1'b0, d_mem_addr[1:0]};
  assign tohost_hit = (d_mem_addr[31:2] == TOHOST_ADDR[31:2]) && (d_mem_wen != 4'b0000);
  assign full_hit   = tohost_hit && (d_mem_wen == 4'b1111);
  assign part_hit   = tohost_hit && (d_mem_wen != 4'b1111);
  assign pass_hit   = full_hit && (d_mem_wdata == 32'd1);
  assign fail_hit   = full_hit && d_mem_wdata[0] && (d_mem_wdata != 32'd1);
  assign sig_hit    = full_hit && !d_mem_wdata[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
      proto_err   <= 1'b0;
    end else if (start) begin
      // start outranks any store or timeout seen in the same cycle
      state       <= ST_RUN;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
      proto_err   <= 1'b0;
    end else if (state == ST_RUN) begin
      if (part_hit) begin
        proto_err <= 1'b1;
      end
      if (pass_hit) begin
        state       <= ST_PASS;
        busy        <= 1'b0;
        done        <= 1'b1;
        pass        <= 1'b1;
        cycle_count <= cycle_count + 32'd1;
      end else if (fail_hit) begin
        state       <= ST_FAIL;
        busy        <= 1'b0;
        done        <= 1'b1;
        fail        <= 1'b1;
        fail_code   <= d_mem_wdata[31:1];
        cycle_count <= cycle_count + 32'd1;
      end else if (cycle_count == LAST_CYCLE) begin
        // watchdog expiry leaves the count at the last RUN cycle index
        state   <= ST_TIMEOUT;
        busy    <= 1'b0;
        done    <= 1'b1;
        fail    <= 1'b1;
        timeout <= 1'b1;
      end else begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

`ifdef TEST_MON_SIGNATURE_EN
  logic [31:0] sig_value_reg;
  logic [15:0] sig_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_value_reg <= '0;
      sig_count_reg <= '0;
    end else if (start) begin
      sig_value_reg <= '0;
      sig_count_reg <= '0;
    end else if ((state == ST_RUN) && sig_hit) begin
      sig_value_reg <= d_mem_wdata;
      if (sig_count_reg != 16'hFFFF) begin
        sig_count_reg <= sig_count_reg + 16'd1;
      end
    end
  end

  assign sig_value = sig_value_reg;
  assign sig_count = sig_count_reg;
`else
  logic unused_sig_hit;
  assign unused_sig_hit = sig_hit;
  assign sig_value = '0;
  assign sig_count = '0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench for test_status_monitor: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic        busy, done, pass, fail, timeout, proto_err;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, sig_value;
  logic [15:0] sig_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic        proto_err;
    logic [31:0] sig_value;
    logic [15:0] sig_count;
  } snap_t;

  snap_t sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  test_status_monitor #(
    .TOHOST_ADDR   (32'h0000_1000),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .d_mem_addr (d_mem_addr),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_wen  (d_mem_wen),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count),
    .proto_err  (proto_err),
    .sig_value  (sig_value),
    .sig_count  (sig_count)
  );

  function automatic logic [31:0] sv_exp(input logic [31:0] v);
`ifdef TEST_MON_SIGNATURE_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic logic [15:0] sc_exp(input logic [15:0] v);
`ifdef TEST_MON_SIGNATURE_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", tag, field, act, exp);
    end
  endtask

  // monitor: consumes every queued snapshot on the falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      snap_t e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "busy",        {31'd0, busy},      {31'd0, e.busy});
      cmp(t, "done",        {31'd0, done},      {31'd0, e.done});
      cmp(t, "pass",        {31'd0, pass},      {31'd0, e.pass});
      cmp(t, "fail",        {31'd0, fail},      {31'd0, e.fail});
      cmp(t, "timeout",     {31'd0, timeout},   {31'd0, e.timeout});
      cmp(t, "fail_code",   {1'b0, fail_code},  {1'b0, e.fail_code});
      cmp(t, "cycle_count", cycle_count,        e.cycle_count);
      cmp(t, "proto_err",   {31'd0, proto_err}, {31'd0, e.proto_err});
      cmp(t, "sig_value",   sig_value,          e.sig_value);
      cmp(t, "sig_count",   {16'd0, sig_count}, {16'd0, e.sig_count});
      $display("check %s: busy=%b done=%b pass=%b fail=%b to=%b fc=%0d cc=%0d pe=%b sv=%h sc=%0d",
               t, busy, done, pass, fail, timeout, fail_code, cycle_count, proto_err, sig_value, sig_count);
    end
  end

  task automatic expect_out(input string tag, input logic b, input logic d, input logic p, input logic f,
                            input logic to, input logic [30:0] fc, input logic [31:0] cc, input logic pe,
                            input logic [31:0] sv, input logic [15:0] sc);
    snap_t e;
    e = '{busy: b, done: d, pass: p, fail: f, timeout: to, fail_code: fc, cycle_count: cc,
          proto_err: pe, sig_value: sv_exp(sv), sig_count: sc_exp(sc)};
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    d_mem_addr  = 32'h0;
    d_mem_wdata = 32'h0;
    d_mem_wen   = 4'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    d_mem_addr  = a;
    d_mem_wdata = w;
    d_mem_wen   = be;
    tick();
    idle_bus();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    idle_bus();
    #1;
    expect_out("reset", 0,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_out("idle", 0,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);

    // pass after 20 idle RUN cycles, with one non-tohost store ignored
    pulse_start();
    expect_out("run_start", 1,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) store(32'h0000_2000, 32'h1, 4'hF);
      else tick();
    end
    expect_out("run_20", 1,0,0,0,0, 31'd0, 32'd20, 0, 32'd0, 16'd0);
    store(32'h0000_1000, 32'h1, 4'hF);
    expect_out("pass", 0,1,1,0,0, 31'd0, 32'd21, 0, 32'd0, 16'd0);
    tick();
    tick();
    expect_out("pass_frozen", 0,1,1,0,0, 31'd0, 32'd21, 0, 32'd0, 16'd0);

    // restart from PASS, then fail with code 3
    pulse_start();
    expect_out("restart", 1,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);
    store(32'h0000_1000, 32'h0000_0007, 4'hF);
    expect_out("fail", 0,1,0,1,0, 31'd3, 32'd1, 0, 32'd0, 16'd0);
    store(32'h0000_1000, 32'h1, 4'hF);
    expect_out("fail_sticky", 0,1,0,1,0, 31'd3, 32'd1, 0, 32'd0, 16'd0);

    // partial hit and two signature writes
    pulse_start();
    store(32'h0000_1002, 32'h1, 4'b0011);
    expect_out("proto_err", 1,0,0,0,0, 31'd0, 32'd1, 1, 32'd0, 16'd0);
    store(32'h0000_1000, 32'h0000_00A0, 4'hF);
    expect_out("sig1", 1,0,0,0,0, 31'd0, 32'd2, 1, 32'h0000_00A0, 16'd1);
    store(32'h0000_1000, 32'h0000_00B0, 4'hF);
    expect_out("sig2", 1,0,0,0,0, 31'd0, 32'd3, 1, 32'h0000_00B0, 16'd2);

    // restart mid-RUN clears captures
    pulse_start();
    expect_out("run_restart", 1,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);

    // watchdog: 49 cycles to reach the last index, one more to expire
    for (int i = 0; i < 49; i++) tick();
    expect_out("run_49", 1,0,0,0,0, 31'd0, 32'd49, 0, 32'd0, 16'd0);
    tick();
    expect_out("timeout", 0,1,0,1,1, 31'd0, 32'd49, 0, 32'd0, 16'd0);
    store(32'h0000_1000, 32'h0000_0003, 4'hF);
    store(32'h0000_1000, 32'h0000_0003, 4'b1000);
    store(32'h0000_1000, 32'h0000_00C0, 4'hF);
    expect_out("timeout_sticky", 0,1,0,1,1, 31'd0, 32'd49, 0, 32'd0, 16'd0);

    // terminal write on the timeout cycle: PASS wins
    pulse_start();
    for (int i = 0; i < 49; i++) tick();
    store(32'h0000_1000, 32'h1, 4'hF);
    expect_out("pass_vs_timeout", 0,1,1,0,0, 31'd0, 32'd50, 0, 32'd0, 16'd0);

    // start together with a failing write: start wins
    start = 1'b1;
    store(32'h0000_1000, 32'h0000_0007, 4'hF);
    start = 1'b0;
    expect_out("start_vs_write", 1,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);

    // asynchronous reset mid-RUN
    store(32'h0000_1000, 32'h0000_0010, 4'hF);
    store(32'h0000_1001, 32'h0, 4'b0100);
    tick();
    expect_out("pre_reset", 1,0,0,0,0, 31'd0, 32'd3, 1, 32'h0000_0010, 16'd1);
    tick();
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 0,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    expect_out("post_reset", 0,0,0,0,0, 31'd0, 32'd0, 0, 32'd0, 16'd0);

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t want=finish_before_limit", $time);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/test_status_monitor.md
# test_status_monitor

Synthesizable observer on the CPU data-memory port that decides the outcome of a self-checking test program. It sits downstream of `cpu_top`, beside the data memory, and snoops every store. It recognises pass/fail writes to a dedicated `tohost` word, runs a cycle watchdog, and presents sticky, registered verdict outputs. Benches and FPGA builds use these outputs in place of probing register-file internals.

## Interface
Parameters:
- `TOHOST_ADDR`, 32'h0000_1000: byte address of the verdict word; only bits [31:2] are compared.
- `TIMEOUT_CYCLES`, 10000: number of RUN cycles allowed before the TIMEOUT verdict.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins, or restarts, a run.
- `d_mem_addr`  in  32  data-port byte address from the CPU.
- `d_mem_wdata`  in  32  data-port store data.
- `d_mem_wen`  in  4  data-port byte write enables; 4'b0000 means no store.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in PASS, FAIL or TIMEOUT.
- `pass`  out  1  high in PASS.
- `fail`  out  1  high in FAIL or TIMEOUT.
- `timeout`  out  1  high in TIMEOUT.
- `fail_code`  out  31  `d_mem_wdata[31:1]` captured from the failing write.
- `cycle_count`  out  32  number of RUN cycles elapsed.
- `proto_err`  out  1  sticky flag: a partial-word store hit `tohost` during RUN.
- `sig_value`  out  32  last signature word (see Configuration).
- `sig_count`  out  16  number of signature writes (see Configuration).

## Operation
- State machine: IDLE, RUN, PASS, FAIL, TIMEOUT.
- Reset value of every output is 0. The state resets to IDLE.
- IDLE -> RUN on `start`. Entering RUN clears `cycle_count`, `fail_code`, `proto_err`, `sig_value` and `sig_count`.
- `tohost` hit: `d_mem_addr[31:2] == TOHOST_ADDR[31:2]` and `d_mem_wen != 0`.
- Full-word hit (`d_mem_wen == 4'b1111`) in RUN:
  - `wdata == 32'd1` -> PASS.
  - `wdata[0] == 1` with any other value -> FAIL, and `fail_code <= wdata[31:1]`.
  - `wdata[0] == 0` -> signature write; state stays RUN.
- Partial-word hit in RUN: `proto_err <= 1`; no state change.
- Hits outside RUN are ignored.
- Non-`tohost` stores are ignored in every state.
- `cycle_count` increments by 1 each RUN cycle. It is frozen in PASS, FAIL and TIMEOUT, and holds its last value in IDLE.
- RUN -> TIMEOUT when `cycle_count == TIMEOUT_CYCLES-1` and no terminal write occurs in that cycle.
- PASS, FAIL and TIMEOUT are sticky. `start` in any of them re-enters RUN with the same clearing rules as IDLE -> RUN.
- `start` during RUN restarts the run: counters and captures are cleared and the state stays RUN.

## Timing
- Every output is a register driven straight from state or registered data; there is no combinational path from inputs to outputs.
- Verdict latency: a terminal store sampled at edge N makes `done`/`pass`/`fail` visible after edge N, i.e. one cycle later.
- `busy` rises the cycle after `start` is sampled.
- The first RUN cycle sees `cycle_count == 0`.
- Simultaneous events, with the required outcome:
  - A terminal write and the timeout condition in the same cycle: the write wins and the verdict is PASS or FAIL.
  - `start` and a terminal write in the same cycle: `start` wins, giving a fresh RUN with counts cleared.
  - A signature write and a partial hit cannot coincide, because a cycle carries only one store.
- Reset asserted mid-run: all state returns to IDLE/0 immediately (asynchronous), with no verdict retained.

## Configuration
- Macro: `TEST_MON_SIGNATURE_EN`.
- When defined, each RUN signature write:
  - sets `sig_value <= wdata`;
  - increments `sig_count`, which saturates at 16'hFFFF.
- When undefined:
  - `sig_value` and `sig_count` are tied to 0 and their registers are not built;
  - signature writes are still treated as non-terminal and produce no error.

## Test plan
- **Pass:** reset, `start`, then 20 idle cycles, then a `tohost` store with wdata=32'h1 and wen=4'hF. Required: `pass` and `done` high one cycle later, `cycle_count`=21 and frozen, `fail`=0.
- **Fail:** `start`, then a `tohost` store with wdata=32'h0000_0007. Required: `fail`=1, `fail_code`=3, `timeout`=0.
- **Timeout:** `TIMEOUT_CYCLES`=50, `start`, no stores. Required: `timeout`=`fail`=1 after the 50th RUN cycle, `cycle_count`=49. Repeat with wdata=1 stored on cycle 49; required: PASS wins.
- **Protocol error and signature:** a `tohost` store with wen=4'b0011 gives `proto_err`=1 with the state still RUN. Two full-word stores of 32'h0000_00A0 and 32'h0000_00B0 give `sig_value`=32'hB0 and `sig_count`=2 with the macro defined, and 0/0 without it.
- **Restart and reset:** `start` in PASS re-enters RUN with all captures cleared. `rst_n` dropped mid-RUN forces every output to 0 before the next clock edge.
